// File: rtl/ipsmacge_pkg.sv
// ipsmacge_pkg: definitions shared by the GE MAC pause-frame logic.
//   - pau_state_e : the 2-bit state encoding of the transmit pause scheduler
//   - QBYTE_DEF   : byte-time strobes per pause quanta (512 bit times)
//   - PAU_DA, PAU_TYPE, PAU_OPCODE : MAC control frame fields, shared with the
//     transmit framer that builds the pause frame
package ipsmacge_pkg;

  localparam int QBYTE_DEF = 64;

  localparam logic [47:0] PAU_DA     = 48'h01_80_C2_00_00_01;
  localparam logic [15:0] PAU_TYPE   = 16'h8808;
  localparam logic [15:0] PAU_OPCODE = 16'h0001;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_XOFF_REQ  = 2'd1,
    ST_XOFF_HOLD = 2'd2,
    ST_XON_REQ   = 2'd3
  } pau_state_e;

endpackage : ipsmacge_pkg

// File: rtl/ipsmacge_quantimer.sv
// ipsmacge_quantimer: byte-time to pause-quanta prescaler plus the XOFF refresh
// down-counter.
//   clk, rst_  : clock, asynchronous active-low reset
//   clr        : synchronous clear of both counters (held while not pausing)
//   load       : clear the prescaler and load the refresh counter with ldval
//   ldval      : refresh interval in quanta; 0 disables the refresh
//   byte_stb   : one pulse per transmitted byte time
//   expire     : one-cycle pulse, a quanta tick while the refresh count is 1
module ipsmacge_quantimer
  import ipsmacge_pkg::*;
#(
  parameter int QNT_W = 16,
  parameter int QBYTE = QBYTE_DEF
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             clr,
  input  logic             load,
  input  logic [QNT_W-1:0] ldval,
  input  logic             byte_stb,
  output logic             expire
);

  localparam int                BCNT_W   = (QBYTE > 1) ? $clog2(QBYTE) : 1;
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(QBYTE - 1);
  localparam logic [QNT_W-1:0]  RCNT_ONE = QNT_W'(1);

  logic [BCNT_W-1:0] bcnt;
  logic [QNT_W-1:0]  rcnt;
  logic              tick;

  // A tick is the wrap of the byte counter; it is meaningless while cleared.
  assign tick   = byte_stb & (bcnt == BCNT_MAX) & ~clr & ~load;
  // A count of 0 never matches, so ldval = 0 disables the refresh entirely.
  assign expire = tick & (rcnt == RCNT_ONE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      bcnt <= '0;
      rcnt <= '0;
    end else if (load) begin
      // load outranks clr: the load edge is also the last edge outside hold.
      bcnt <= '0;
      rcnt <= ldval;
    end else if (clr) begin
      bcnt <= '0;
      rcnt <= '0;
    end else begin
      if (byte_stb) begin
        bcnt <= (bcnt == BCNT_MAX) ? '0 : bcnt + BCNT_W'(1);
      end
      // Floor at 1 so the counter keeps expiring on every later tick.
      if (tick && (rcnt > RCNT_ONE)) begin
        rcnt <= rcnt - RCNT_ONE;
      end
    end
  end

endmodule : ipsmacge_quantimer

// File: rtl/ipsmacge_txpausectl.sv
// ipsmacge_txpausectl: transmit flow-control scheduler for the GE MAC.
// Watches the receive-FIFO level and asks the framer for XOFF (programmed
// quanta) or XON (quanta 0) pause frames, re-sending XOFF on a refresh timer
// while the link partner is paused.
//   txclk, txrst_        : clock, asynchronous active-low reset
//   up_act               : port active; 0 synchronously clears FSM and timers
//   up_pauen             : pause generation enable
//   up_quanta/up_refresh : XOFF quanta, XOFF re-send interval (0 = none)
//   up_hiwm/up_lowm      : XOFF / XON watermarks (up_lowm < up_hiwm)
//   fifo_lvl             : receive-FIFO occupancy
//   byte_stb             : one pulse per transmitted byte time
//   pa_ack               : framer started a pause frame (acknowledge)
//   pa_ien/pa_off/oquanta: pause request, XON flag, quanta for the framer
//   pau_act              : link partner considered paused
//   st_xoff/st_xon       : saturating frame counters, cleared by clr_stat
module ipsmacge_txpausectl
  import ipsmacge_pkg::*;
#(
  parameter int LVL_W = 10,
  parameter int QNT_W = 16,
  parameter int QBYTE = QBYTE_DEF,
  parameter int STC_W = 16
) (
  input  logic             txclk,
  input  logic             txrst_,
  input  logic             up_act,
  input  logic             up_pauen,
  input  logic [QNT_W-1:0] up_quanta,
  input  logic [QNT_W-1:0] up_refresh,
  input  logic [LVL_W-1:0] up_hiwm,
  input  logic [LVL_W-1:0] up_lowm,
  input  logic [LVL_W-1:0] fifo_lvl,
  input  logic             byte_stb,
  input  logic             pa_ack,
  output logic             pa_ien,
  output logic             pa_off,
  output logic [QNT_W-1:0] oquanta,
  output logic             pau_act,
  output logic [STC_W-1:0] st_xoff,
  output logic [STC_W-1:0] st_xon,
  input  logic             clr_stat
);

  pau_state_e state;
  logic       xoff_cond;
  logic       xon_cond;
  logic       xoff_ack;
  logic       xon_ack;
  logic       expire;

  assign xoff_ack = up_act & pa_ack & (state == ST_XOFF_REQ);
  assign xon_ack  = up_act & pa_ack & (state == ST_XON_REQ);

  // Watermark decisions are registered once, so the FSM sees a level change
  // one cycle later and the FIFO-level compare stays off the FSM path.
  always_ff @(posedge txclk or negedge txrst_) begin
    if (!txrst_) begin
      xoff_cond <= 1'b0;
      xon_cond  <= 1'b0;
    end else if (!up_act) begin
      xoff_cond <= 1'b0;
      xon_cond  <= 1'b0;
    end else begin
      xoff_cond <= up_pauen & (fifo_lvl >= up_hiwm);
      xon_cond  <= ~up_pauen | (fifo_lvl <= up_lowm);
    end
  end

  ipsmacge_quantimer #(
    .QNT_W (QNT_W),
    .QBYTE (QBYTE)
  ) u_quantimer (
    .clk      (txclk),
    .rst_     (txrst_),
    .clr      (~up_act | (state != ST_XOFF_HOLD)),
    .load     (xoff_ack),
    .ldval    (up_refresh),
    .byte_stb (byte_stb),
    .expire   (expire)
  );

  // pa_off and oquanta are written only on entry to a REQ state; the framer
  // samples them after SFD, i.e. after pa_ack, so they must not move then.
  always_ff @(posedge txclk or negedge txrst_) begin
    if (!txrst_) begin
      state   <= ST_IDLE;
      pa_ien  <= 1'b0;
      pa_off  <= 1'b0;
      oquanta <= '0;
      pau_act <= 1'b0;
    end else if (!up_act) begin
      state   <= ST_IDLE;
      pa_ien  <= 1'b0;
      pa_off  <= 1'b0;
      oquanta <= '0;
      pau_act <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xoff_cond) begin
            state   <= ST_XOFF_REQ;
            pa_ien  <= 1'b1;
            pa_off  <= 1'b0;
            oquanta <= up_quanta;
          end
        end
        ST_XOFF_REQ: begin
          if (pa_ack) begin
            state   <= ST_XOFF_HOLD;
            pa_ien  <= 1'b0;
            pau_act <= 1'b1;
          end
        end
        ST_XOFF_HOLD: begin
          if (xon_cond) begin
            state   <= ST_XON_REQ;
            pa_ien  <= 1'b1;
            pa_off  <= 1'b1;
            oquanta <= '0;
          end else if (expire) begin
            state   <= ST_XOFF_REQ;
            pa_ien  <= 1'b1;
            pa_off  <= 1'b0;
            oquanta <= up_quanta;
          end
        end
        ST_XON_REQ: begin
          // An ack beats a new XOFF demand; that demand is seen from IDLE.
          if (pa_ack) begin
            state   <= ST_IDLE;
            pa_ien  <= 1'b0;
            pau_act <= 1'b0;
          end else if (xoff_cond) begin
            state   <= ST_XOFF_REQ;
            pa_ien  <= 1'b1;
            pa_off  <= 1'b0;
            oquanta <= up_quanta;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Statistics survive up_act; only txrst_ and clr_stat clear them.
  always_ff @(posedge txclk or negedge txrst_) begin
    if (!txrst_) begin
      st_xoff <= '0;
      st_xon  <= '0;
    end else if (clr_stat) begin
      st_xoff <= '0;
      st_xon  <= '0;
    end else begin
      if (xoff_ack && (st_xoff != '1)) begin
        st_xoff <= st_xoff + STC_W'(1);
      end
      if (xon_ack && (st_xon != '1)) begin
        st_xon <= st_xon + STC_W'(1);
      end
    end
  end

endmodule : ipsmacge_txpausectl

// File: tb/tb_ipsmacge_txpausectl.sv
// Directed bench for ipsmacge_txpausectl. Inputs change 1 ns after a rising
// edge and outputs are read 1 ns after a rising edge. Statistic counters are
// instantiated 8 bits wide so that saturation is reachable in a short run.
module tb_ipsmacge_txpausectl;

  localparam int LVL_W = 10;
  localparam int QNT_W = 16;
  localparam int STC_W = 8;

  logic             txclk;
  logic             txrst_;
  logic             up_act;
  logic             up_pauen;
  logic [QNT_W-1:0] up_quanta;
  logic [QNT_W-1:0] up_refresh;
  logic [LVL_W-1:0] up_hiwm;
  logic [LVL_W-1:0] up_lowm;
  logic [LVL_W-1:0] fifo_lvl;
  logic             byte_stb;
  logic             pa_ack;
  logic             pa_ien;
  logic             pa_off;
  logic [QNT_W-1:0] oquanta;
  logic             pau_act;
  logic [STC_W-1:0] st_xoff;
  logic [STC_W-1:0] st_xon;
  logic             clr_stat;

  int errors = 0;
  int checks = 0;

  ipsmacge_txpausectl #(
    .LVL_W (LVL_W),
    .QNT_W (QNT_W),
    .QBYTE (64),
    .STC_W (STC_W)
  ) dut (
    .txclk      (txclk),
    .txrst_     (txrst_),
    .up_act     (up_act),
    .up_pauen   (up_pauen),
    .up_quanta  (up_quanta),
    .up_refresh (up_refresh),
    .up_hiwm    (up_hiwm),
    .up_lowm    (up_lowm),
    .fifo_lvl   (fifo_lvl),
    .byte_stb   (byte_stb),
    .pa_ack     (pa_ack),
    .pa_ien     (pa_ien),
    .pa_off     (pa_off),
    .oquanta    (oquanta),
    .pau_act    (pau_act),
    .st_xoff    (st_xoff),
    .st_xon     (st_xon),
    .clr_stat   (clr_stat)
  );

  initial txclk = 1'b0;
  always #5 txclk = ~txclk;

  task automatic step(input int n);
    repeat (n) @(posedge txclk);
    #1;
  endtask

  task automatic ack_pulse();
    pa_ack = 1'b1;
    step(1);
    pa_ack = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (pa_ien !== 1'b0) begin errors++; $display("FAIL reset_ien: got %b want 0", pa_ien); end
    checks++; if (pa_off !== 1'b0) begin errors++; $display("FAIL reset_off: got %b want 0", pa_off); end
    checks++; if (oquanta !== 16'h0000) begin errors++; $display("FAIL reset_quanta: got %h want 0000", oquanta); end
    checks++; if (pau_act !== 1'b0) begin errors++; $display("FAIL reset_pau_act: got %b want 0", pau_act); end
    checks++; if (st_xoff !== 8'd0 || st_xon !== 8'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", st_xoff, st_xon); end
    step(1);
    txrst_ = 1'b1;
    step(2);
    checks++; if (pa_ien !== 1'b0) begin errors++; $display("FAIL idle_low_lvl: got ien %b want 0", pa_ien); end
  endtask

  task automatic test_xoff();
    for (int l = 0; l <= 500; l += 100) begin
      fifo_lvl = LVL_W'(l);
      step(1);
      checks++; if (pa_ien !== 1'b0) begin errors++; $display("FAIL ramp_ien lvl=%0d: got %b want 0", l, pa_ien); end
    end
    fifo_lvl = 10'd600;
    step(1);
    checks++; if (pa_ien !== 1'b0) begin errors++; $display("FAIL xoff_early: got ien %b want 0", pa_ien); end
    step(1);
    checks++; if (pa_ien !== 1'b1) begin errors++; $display("FAIL xoff_ien: got %b want 1", pa_ien); end
    checks++; if (pa_off !== 1'b0) begin errors++; $display("FAIL xoff_off: got %b want 0", pa_off); end
    checks++; if (oquanta !== 16'h00FF) begin errors++; $display("FAIL xoff_quanta: got %h want 00ff", oquanta); end
    checks++; if (pau_act !== 1'b0) begin errors++; $display("FAIL xoff_pau_pre: got %b want 0", pau_act); end
    ack_pulse();
    checks++; if (pa_ien !== 1'b0) begin errors++; $display("FAIL xoff_ack_ien: got %b want 0", pa_ien); end
    checks++; if (pau_act !== 1'b1) begin errors++; $display("FAIL xoff_ack_pau: got %b want 1", pau_act); end
    checks++; if (st_xoff !== 8'd1) begin errors++; $display("FAIL xoff_stat: got %0d want 1", st_xoff); end
  endtask

  // Refresh of 2 quanta with a byte strobe every cycle: 2*64 = 128 cycles.
  task automatic test_refresh();
    step(127);
    checks++; if (pa_ien !== 1'b0) begin errors++; $display("FAIL refresh_early: got ien %b want 0 at 127", pa_ien); end
    step(1);
    checks++; if (pa_ien !== 1'b1) begin errors++; $display("FAIL refresh_ien: got %b want 1 at 128", pa_ien); end
    checks++; if (pa_off !== 1'b0 || oquanta !== 16'h00FF) begin errors++; $display("FAIL refresh_fields: got off %b q %h want 0/00ff", pa_off, oquanta); end
    checks++; if (pau_act !== 1'b1) begin errors++; $display("FAIL refresh_pau: got %b want 1", pau_act); end
    up_refresh = 16'd0;
    ack_pulse();
    checks++; if (st_xoff !== 8'd2) begin errors++; $display("FAIL refresh_stat: got %0d want 2", st_xoff); end
  endtask

  task automatic test_no_refresh();
    bit seen = 1'b0;
    repeat (10000) begin
      step(1);
      if (pa_ien) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL no_refresh: got request %b want 0", seen); end
    checks++; if (pau_act !== 1'b1) begin errors++; $display("FAIL no_refresh_pau: got %b want 1", pau_act); end
  endtask

  task automatic test_xon();
    fifo_lvl = 10'd128;
    step(1);
    checks++; if (pa_ien !== 1'b0) begin errors++; $display("FAIL xon_early: got ien %b want 0", pa_ien); end
    step(1);
    checks++; if (pa_ien !== 1'b1 || pa_off !== 1'b1) begin errors++; $display("FAIL xon_req: got ien %b off %b want 1/1", pa_ien, pa_off); end
    checks++; if (oquanta !== 16'h0000) begin errors++; $display("FAIL xon_quanta: got %h want 0000", oquanta); end
    ack_pulse();
    checks++; if (pa_ien !== 1'b0 || pau_act !== 1'b0) begin errors++; $display("FAIL xon_ack: got ien %b pau %b want 0/0", pa_ien, pau_act); end
    checks++; if (pa_off !== 1'b1) begin errors++; $display("FAIL xon_off_stable: got %b want 1", pa_off); end
    checks++; if (st_xon !== 8'd1 || st_xoff !== 8'd2) begin errors++; $display("FAIL xon_stats: got %0d/%0d want 2/1", st_xoff, st_xon); end
  endtask

  task automatic test_xon_abort();
    fifo_lvl = 10'd600;
    step(2);
    checks++; if (pa_ien !== 1'b1 || pa_off !== 1'b0) begin errors++; $display("FAIL abort_xoff: got ien %b off %b want 1/0", pa_ien, pa_off); end
    ack_pulse();
    checks++; if (st_xoff !== 8'd3) begin errors++; $display("FAIL abort_xoff_stat: got %0d want 3", st_xoff); end
    fifo_lvl = 10'd100;
    step(2);
    checks++; if (pa_ien !== 1'b1 || pa_off !== 1'b1 || oquanta !== 16'h0000) begin errors++; $display("FAIL abort_xon_req: got ien %b off %b q %h want 1/1/0000", pa_ien, pa_off, oquanta); end
    fifo_lvl = 10'd520;
    step(1);
    checks++; if (pa_off !== 1'b1) begin errors++; $display("FAIL abort_latency: got off %b want 1", pa_off); end
    step(1);
    checks++; if (pa_ien !== 1'b1 || pa_off !== 1'b0 || oquanta !== 16'h00FF) begin errors++; $display("FAIL abort_relatch: got ien %b off %b q %h want 1/0/00ff", pa_ien, pa_off, oquanta); end
    ack_pulse();
    checks++; if (st_xoff !== 8'd4 || st_xon !== 8'd1) begin errors++; $display("FAIL abort_stats: got %0d/%0d want 4/1", st_xoff, st_xon); end
    checks++; if (pau_act !== 1'b1 || pa_ien !== 1'b0) begin errors++; $display("FAIL abort_hold: got pau %b ien %b want 1/0", pau_act, pa_ien); end
  endtask

  task automatic test_ack_ignored();
    ack_pulse();
    checks++; if (st_xoff !== 8'd4 || st_xon !== 8'd1) begin errors++; $display("FAIL stray_ack_stats: got %0d/%0d want 4/1", st_xoff, st_xon); end
    checks++; if (pa_ien !== 1'b0 || pau_act !== 1'b1) begin errors++; $display("FAIL stray_ack_state: got ien %b pau %b want 0/1", pa_ien, pau_act); end
  endtask

  task automatic test_up_act();
    fifo_lvl = 10'd100;
    step(2);
    ack_pulse();
    checks++; if (st_xon !== 8'd2 || pau_act !== 1'b0) begin errors++; $display("FAIL act_xon: got st %0d pau %b want 2/0", st_xon, pau_act); end
    fifo_lvl = 10'd600;
    step(2);
    checks++; if (pa_ien !== 1'b1 || oquanta !== 16'h00FF) begin errors++; $display("FAIL act_xoff_req: got ien %b q %h want 1/00ff", pa_ien, oquanta); end
    up_act = 1'b0;
    step(1);
    checks++; if (pa_ien !== 1'b0 || pa_off !== 1'b0 || oquanta !== 16'h0000 || pau_act !== 1'b0) begin errors++; $display("FAIL act_clear: got ien %b off %b q %h pau %b want all 0", pa_ien, pa_off, oquanta, pau_act); end
    checks++; if (st_xoff !== 8'd4 || st_xon !== 8'd2) begin errors++; $display("FAIL act_stats_kept: got %0d/%0d want 4/2", st_xoff, st_xon); end
    up_act = 1'b1;
    step(1);
    checks++; if (pa_ien !== 1'b0) begin errors++; $display("FAIL act_restart_early: got ien %b want 0", pa_ien); end
    step(1);
    checks++; if (pa_ien !== 1'b1) begin errors++; $display("FAIL act_restart: got ien %b want 1", pa_ien); end
    ack_pulse();
    checks++; if (st_xoff !== 8'd5 || pau_act !== 1'b1) begin errors++; $display("FAIL act_hold: got st %0d pau %b want 5/1", st_xoff, pau_act); end
  endtask

  task automatic test_async_reset();
    #2;
    txrst_ = 1'b0;
    #1;
    checks++; if (pa_ien !== 1'b0 || pa_off !== 1'b0 || oquanta !== 16'h0000 || pau_act !== 1'b0) begin errors++; $display("FAIL async_rst_out: got ien %b off %b q %h pau %b want all 0", pa_ien, pa_off, oquanta, pau_act); end
    checks++; if (st_xoff !== 8'd0 || st_xon !== 8'd0) begin errors++; $display("FAIL async_rst_stats: got %0d/%0d want 0/0", st_xoff, st_xon); end
    step(1);
    txrst_ = 1'b1;
  endtask

  task automatic test_saturation();
    step(2);
    checks++; if (pa_ien !== 1'b1) begin errors++; $display("FAIL sat_first_req: got ien %b want 1", pa_ien); end
    ack_pulse();
    for (int i = 0; i < 254; i++) begin
      fifo_lvl = 10'd100;
      step(2);
      fifo_lvl = 10'd600;
      step(2);
      ack_pulse();
    end
    checks++; if (st_xoff !== 8'hFF) begin errors++; $display("FAIL sat_reach: got %h want ff", st_xoff); end
    fifo_lvl = 10'd100;
    step(2);
    fifo_lvl = 10'd600;
    step(2);
    ack_pulse();
    checks++; if (st_xoff !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %h want ff", st_xoff); end
    checks++; if (st_xon !== 8'd0) begin errors++; $display("FAIL sat_xon: got %0d want 0", st_xon); end
    fifo_lvl = 10'd100;
    step(2);
    fifo_lvl = 10'd600;
    step(2);
    clr_stat = 1'b1;
    ack_pulse();
    clr_stat = 1'b0;
    checks++; if (st_xoff !== 8'd0) begin errors++; $display("FAIL clr_vs_ack: got %h want 00", st_xoff); end
    checks++; if (pau_act !== 1'b1) begin errors++; $display("FAIL clr_ack_state: got pau %b want 1", pau_act); end
  endtask

  initial begin
    txrst_     = 1'b0;
    up_act     = 1'b1;
    up_pauen   = 1'b1;
    up_quanta  = 16'h00FF;
    up_refresh = 16'd2;
    up_hiwm    = 10'd512;
    up_lowm    = 10'd128;
    fifo_lvl   = '0;
    byte_stb   = 1'b1;
    pa_ack     = 1'b0;
    clr_stat   = 1'b0;

    test_reset();
    test_xoff();
    test_refresh();
    test_no_refresh();
    test_xon();
    test_xon_abort();
    test_ack_ignored();
    test_up_act();
    test_async_reset();
    test_saturation();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ipsmacge_txpausectl

// File: doc/ipsmacge_txpausectl.md
Name: ipsmacge_txpausectl

Overview:
Flow-control scheduler for the GE MAC transmit path. It watches the receive-FIFO fill level and decides when the transmit framer sends an XOFF pause frame (programmed quanta) or an XON pause frame (quanta 0). While the link partner is paused, it re-issues XOFF on a refresh timer measured in pause quanta. It drives the framer's pause request, pause-off and quanta inputs, and takes the framer's start-of-frame strobe as the acknowledge.

Parameters:
LVL_W, 10, width of FIFO level and watermark fields
QNT_W, 16, width of quanta and refresh fields
QBYTE, 64, byte-time strobes per pause quanta (512 bit times)
STC_W, 16, width of the saturating statistics counters

Ports:
txclk  in  1  transmit clock
txrst_  in  1  asynchronous active-low reset
up_act  in  1  port active; 0 = synchronous clear of FSM, timers and outputs
up_pauen  in  1  pause generation enable
up_quanta  in  QNT_W  quanta value sent in XOFF frames
up_refresh  in  QNT_W  XOFF re-send interval in quanta; 0 = no refresh
up_hiwm  in  LVL_W  XOFF watermark
up_lowm  in  LVL_W  XON watermark; the design requires up_lowm < up_hiwm
fifo_lvl  in  LVL_W  receive-FIFO occupancy
byte_stb  in  1  one pulse per transmitted byte time (framer pa_oval)
pa_ack  in  1  framer started a pause frame (SFD cycle of a pause frame)
pa_ien  out  1  pause frame request
pa_off  out  1  1 = XON (quanta 0), 0 = XOFF
oquanta  out  QNT_W  quanta for the framer
pau_act  out  1  link partner is considered paused
st_xoff  out  STC_W  XOFF frames sent
st_xon  out  STC_W  XON frames sent
clr_stat  in  1  synchronous clear of st_xoff and st_xon

Behaviour:
- Reset values, also forced by up_act=0 on the next edge: state IDLE, pa_ien=0, pa_off=0, oquanta=0, pau_act=0, timers=0. Statistics reset only on txrst_ or clr_stat.
- FSM states: IDLE, XOFF_REQ, XOFF_HOLD, XON_REQ. All outputs are registered, so there is 1-cycle latency from a condition to an output change.
- IDLE: if up_pauen & fifo_lvl>=up_hiwm, go to XOFF_REQ.
- Entering XOFF_REQ: latch oquanta=up_quanta, pa_off=0, pa_ien=1.
  - On pa_ack: go to XOFF_HOLD; pa_ien=0; pau_act=1; st_xoff+1; load refresh counter = up_refresh.
- XOFF_HOLD, priority order:
  - (!up_pauen | fifo_lvl<=up_lowm): go to XON_REQ.
  - else refresh counter==1 and a quanta tick occurs: go to XOFF_REQ.
  - When up_refresh=0, the refresh counter is held at 0 and never triggers.
- Entering XON_REQ: latch oquanta=0, pa_off=1, pa_ien=1.
  - On pa_ack: go to IDLE; pa_ien=0; pau_act=0; st_xon+1.
  - If fifo_lvl>=up_hiwm & up_pauen before pa_ack: go to XOFF_REQ and re-latch the XOFF fields.
- pa_off and oquanta change only on entry to a REQ state. They stay stable after pa_ack until the next REQ entry, because the framer samples them after SFD.
- pa_ack outside a REQ state: ignored.
- pa_ack on the same cycle as a state-changing condition: pa_ack wins, and the other condition is evaluated in the next cycle.
- Quanta tick:
  - A 6-bit byte counter increments on byte_stb and wraps at QBYTE-1; the tick fires on wrap.
  - The counter runs only in XOFF_HOLD and is cleared on entry to XOFF_HOLD.
- Refresh counter decrements on each tick, with a floor at 1 while in XOFF_HOLD.
- Statistics saturate at all-ones. clr_stat takes priority over an increment on the same cycle.

Decomposition:
- Shared package ipsmacge_pkg holds:
  - state encodings (2-bit)
  - QBYTE default
  - PAU_DA, PAU_TYPE and PAU_OPCODE constants, shared with the framer
- Sub-module ipsmacge_quantimer contains the byte-to-quanta prescaler plus the refresh down-counter. Ports: clk, rst_, clr, load, ldval, byte_stb, expire.

Test Plan:
- up_pauen=1, fifo_lvl ramps 0 to 600 with hiwm=512, lowm=128: pa_ien rises 2 cycles after lvl>=512 with pa_off=0 and oquanta=up_quanta=0x00FF. pa_ack clears pa_ien next cycle and sets pau_act=1; st_xoff=1.
- In hold with up_refresh=2 and byte_stb every cycle: a second XOFF pa_ien appears exactly 128 cycles after the first pa_ack. up_refresh=0 gives no re-request over 10000 cycles.
- In hold, lvl drops to 128: pa_ien=1 with pa_off=1 and oquanta=0. pa_ack returns the block to IDLE with pau_act=0; st_xon=1.
- In XON_REQ, lvl rises to 520 before pa_ack: pa_off returns to 0 and oquanta to 0x00FF while pa_ien stays 1. The ack counts as XOFF.
- up_act deasserted mid-XOFF_REQ: all outputs are 0 next cycle. txrst_ asserted in XOFF_HOLD clears everything asynchronously, including the statistics.
- Statistics preloaded to 0xFFFF, then one more pa_ack: st_xoff stays 0xFFFF. clr_stat together with pa_ack gives 0.
